io_port_ctrl: RTL
=================

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter n, default 16: data width of the I/O ports and of the register values.
REQ-002 Parameter TIMEOUT, default 255: maximum number of wait cycles before a device handshake aborts; counter width is 8 bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 EX_IN  input  1  EX-stage IN instruction flag, taken from the ID/EX pipeline register.
REQ-006 EX_OUT  input  1  EX-stage OUT instruction flag, taken from the ID/EX pipeline register.
REQ-007 EX_ReadData1  input  n  value to be output by the OUT instruction.
REQ-008 io_stall  output  1  combinational freeze request to the PC, IF/ID and ID/EX registers.
REQ-009 io_in_data  output  n  last value captured by an IN instruction, forwarded to writeback.
REQ-010 io_err  output  1  sticky flag set on timeout or on EX_IN and EX_OUT being high together.
REQ-011 out_port  output  n  data presented to the external device.
REQ-012 out_valid  output  1  out_port holds valid data.
REQ-013 out_ready  input  1  device accepts out_port.
REQ-014 in_port  input  n  data from the external device.
REQ-015 in_valid  input  1  in_port holds valid data.
REQ-016 in_ready  output  1  block is waiting for input data.

Function
REQ-017 The FSM SHALL have the states IDLE, OUT_WAIT, IN_WAIT and DONE.
REQ-018 IDLE: if EX_OUT, the block SHALL latch EX_ReadData1 into out_port and go to OUT_WAIT; otherwise, if EX_IN, it SHALL go to IN_WAIT; otherwise it SHALL stay in IDLE.
REQ-019 If EX_IN and EX_OUT are both high in IDLE, EX_OUT SHALL take priority and io_err SHALL be set.
REQ-020 out_valid SHALL be a registered output, high exactly while in OUT_WAIT; in_ready SHALL be a registered output, high exactly while in IN_WAIT.
REQ-021 OUT_WAIT: on out_valid and out_ready high in the same cycle, the transfer SHALL complete and the FSM SHALL go to DONE.
REQ-022 IN_WAIT: on in_valid and in_ready high in the same cycle, in_port SHALL be captured into io_in_data and the FSM SHALL go to DONE.
REQ-023 io_in_data SHALL hold its value until the next IN capture or timeout.
REQ-024 io_stall SHALL equal (IDLE and (EX_IN or EX_OUT)) or OUT_WAIT or IN_WAIT, and SHALL be low in DONE.
REQ-025 DONE SHALL last one cycle, SHALL ignore EX_IN and EX_OUT (so the completing instruction cannot retrigger), and SHALL then go to IDLE.
REQ-026 Minimum latency, with the device ready immediately: detect cycle, one wait cycle, DONE — io_stall high for 2 cycles and the instruction resident in EX for 3 cycles.
REQ-027 The wait counter SHALL clear on entry to OUT_WAIT or IN_WAIT and increment each cycle in those states without a handshake.
REQ-028 When the counter equals TIMEOUT without a handshake, the FSM SHALL go to DONE and set io_err; on an IN timeout, io_in_data SHALL load all-ones (16'hFFFF).
REQ-029 A handshake occurring in the same cycle as the timeout SHALL win: transfer completes and io_err is not set.
REQ-030 Back-to-back I/O instructions SHALL each be serviced, separated by exactly one DONE cycle.

Reset
REQ-031 rst high SHALL asynchronously force: state IDLE, counter 0, out_port 0, out_valid 0, in_ready 0, io_in_data 0, io_err 0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no capture; io_stall SHALL follow its equation from IDLE.
REQ-033 io_err SHALL be cleared only by reset.

Structure
REQ-034 The state encoding, the TIMEOUT default and the all-ones error data constant SHALL live in the shared package io_ctrl_pkg.
REQ-035 The wait counter SHALL be the sub-module io_timeout_counter (inputs clr, en; output expired).

Verification
REQ-036 OUT with out_ready tied high, EX_ReadData1=16'h1234 -> out_port=16'h1234, out_valid high 1 cycle, io_stall high 2 cycles, io_err=0.
REQ-037 IN with in_valid and in_port=16'hBEEF raised 5 cycles after in_ready -> io_in_data=16'hBEEF, io_stall high 7 cycles, then DONE then IDLE.
REQ-038 IN with no in_valid, TIMEOUT=255 -> abort after 255 wait cycles, io_in_data=16'hFFFF, io_err=1.
REQ-039 EX_IN and EX_OUT both high -> OUT sequence executed, io_err=1.
REQ-040 rst pulsed in OUT_WAIT -> out_valid=0 and state IDLE in the same cycle; a following OUT completes normally.
REQ-041 Two consecutive OUT instructions (16'h0001, 16'h0002) -> two transfers in order, with exactly one DONE cycle between them.

Source files
------------

// File: rtl/io_ctrl_pkg.sv
// Shared constants and state encoding for the I/O port controller.
// This package is imported by io_port_ctrl and io_timeout_counter.
package io_ctrl_pkg;

  localparam int unsigned IoTimeoutDflt = 255;
  localparam int unsigned IoCntW        = 8;
  localparam logic [15:0] IoErrData     = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StOutWait = 2'd1,
    StInWait  = 2'd2,
    StDone    = 2'd3
  } io_state_e;

endpackage

// File: rtl/io_timeout_counter.sv
// Wait-cycle counter for device handshakes.
// 'expired' goes high when the count reaches Limit.
module io_timeout_counter
  import io_ctrl_pkg::*;
#(
  parameter int unsigned Limit = IoTimeoutDflt
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [IoCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == IoCntW'(Limit));

endmodule

// File: rtl/io_port_ctrl.sv
// IN/OUT instruction controller: stalls the pipeline while a valid/ready
// handshake with the external device completes or times out.
module io_port_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int unsigned n       = 16,
  parameter int unsigned TIMEOUT = IoTimeoutDflt
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EX_IN,
  input  logic         EX_OUT,
  input  logic [n-1:0] EX_ReadData1,
  output logic         io_stall,
  output logic [n-1:0] io_in_data,
  output logic         io_err,
  output logic [n-1:0] out_port,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic [n-1:0] in_port,
  input  logic         in_valid,
  output logic         in_ready
);

  // Replicate the package all-ones error pattern to the port width.
  localparam logic [n-1:0] ErrData = {n{IoErrData[0]}};

  io_state_e    state_q, state_d;
  logic [n-1:0] out_port_q, out_port_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic [n-1:0] in_data_q, in_data_d;
  logic         err_q, err_d;

  logic io_req, out_hs, in_hs, cnt_clr, cnt_en, expired;

  assign io_req  = EX_IN | EX_OUT;
  assign out_hs  = out_valid_q & out_ready;
  assign in_hs   = in_ready_q & in_valid;
  assign cnt_clr = (state_q == StIdle) & io_req;
  assign cnt_en  = ((state_q == StOutWait) & ~out_hs) | ((state_q == StInWait) & ~in_hs);

  io_timeout_counter #(
    .Limit (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    out_port_d  = out_port_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    in_data_d   = in_data_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (EX_OUT) begin
          state_d     = StOutWait;
          out_port_d  = EX_ReadData1;
          out_valid_d = 1'b1;
          if (EX_IN) begin
            err_d = 1'b1;
          end
        end else if (EX_IN) begin
          state_d    = StInWait;
          in_ready_d = 1'b1;
        end
      end
      StOutWait: begin
        // A handshake in the expiry cycle still counts as success.
        if (out_hs || expired) begin
          state_d     = StDone;
          out_valid_d = 1'b0;
          if (!out_hs) begin
            err_d = 1'b1;
          end
        end
      end
      StInWait: begin
        if (in_hs) begin
          state_d    = StDone;
          in_ready_d = 1'b0;
          in_data_d  = in_port;
        end else if (expired) begin
          state_d    = StDone;
          in_ready_d = 1'b0;
          in_data_d  = ErrData;
          err_d      = 1'b1;
        end
      end
      StDone: begin
        // The completing instruction is still in EX; ignore it here.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      in_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_port_q  <= out_port_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      in_data_q   <= in_data_d;
      err_q       <= err_d;
    end
  end

  assign io_stall   = ((state_q == StIdle) & io_req) | (state_q == StOutWait) |
                      (state_q == StInWait);
  assign out_port   = out_port_q;
  assign out_valid  = out_valid_q;
  assign in_ready   = in_ready_q;
  assign io_in_data = in_data_q;
  assign io_err     = err_q;

endmodule
